// File: rtl/video_vga_capture.sv
// VGA receive side: registers the incoming RGB/sync pins, recovers line and
// frame position from the sync edges, validates the timing against the
// parameters and streams active pixels as (x, y, rgb) once locked.
//
// Output stream: pix_valid is a one-cycle strobe with no backpressure. When it
// is high, pix_x/pix_y/pix_rgb and the frame_start/line_start markers describe
// one active pixel. When it is low, pix_x/pix_y/pix_rgb hold their last values.
module video_vga_capture #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  vga_r,
  input  logic [3:0]  vga_g,
  input  logic [3:0]  vga_b,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        line_start,
  output logic        locked,
  output logic        timing_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_MAX    = 11'h7FF;
  localparam logic [10:0] H_SYNC_W = 11'(H_SYNC);
  localparam logic [10:0] H_START  = 11'(H_SYNC + H_BACK_PORCH);
  localparam logic [10:0] H_END    = 11'(H_SYNC + H_BACK_PORCH + H_ACTIVE - 1);

  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'h3FF;
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  // The line opened by an hsync edge carries the next row, hence the -1.
  localparam logic [9:0] V_START  = 10'(V_SYNC + V_BACK_PORCH - 1);
  localparam logic [9:0] V_END    = 10'(V_SYNC + V_BACK_PORCH + V_ACTIVE - 2);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] rgb_s1_q, rgb_s1_d;
  logic        hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
  logic        vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
  logic [10:0] h_cnt_q, h_cnt_d, hs_w_q, hs_w_d;
  logic [9:0]  v_cnt_q, v_cnt_d, vs_w_q, vs_w_d;
  logic        vs_pend_q, vs_pend_d;
  logic        armed_q, armed_d;
  logic [GW-1:0] good_q, good_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [11:0] pix_rgb_q, pix_rgb_d;
  logic        frame_start_q, frame_start_d;
  logic        line_start_q, line_start_d;
  logic        timing_err_q, timing_err_d;

  logic hs_rise, vs_rise, vs_pend_eff, line_ok, frame_ok, h_sat_hit;
  logic in_window;

  // Input capture and position counters; h_cnt_d/v_cnt_d are the position of the pixel in rgb_s1_q.
  always_comb begin
    rgb_s1_d    = {vga_r, vga_g, vga_b};
    hs_s1_d     = vga_hsync;
    vs_s1_d     = vga_vsync;
    hs_s2_d     = hs_s1_q;
    vs_s2_d     = vs_s1_q;
    hs_rise     = hs_s1_q & ~hs_s2_q;
    vs_rise     = vs_s1_q & ~vs_s2_q;
    vs_pend_eff = vs_pend_q | vs_rise;

    h_cnt_d = (h_cnt_q == H_MAX) ? h_cnt_q : h_cnt_q + 11'd1;
    if (hs_rise) h_cnt_d = '0;

    hs_w_d = hs_w_q;
    if (hs_rise) hs_w_d = 11'd1;
    else if (hs_s1_q && hs_w_q != H_MAX) hs_w_d = hs_w_q + 11'd1;

    vs_pend_d = hs_rise ? 1'b0 : vs_pend_eff;

    v_cnt_d = v_cnt_q;
    vs_w_d  = vs_w_q;
    if (hs_rise) begin
      if (vs_pend_eff) begin
        v_cnt_d = '0;
        vs_w_d  = {9'd0, vs_s1_q};
      end else begin
        if (v_cnt_q != V_MAX) v_cnt_d = v_cnt_q + 10'd1;
        if (vs_s1_q && vs_w_q != V_MAX) vs_w_d = vs_w_q + 10'd1;
      end
    end

    line_ok   = (h_cnt_q == H_LAST) && (hs_w_q == H_SYNC_W);
    frame_ok  = (v_cnt_q == V_LAST) && (vs_w_q == V_SYNC_W);
    h_sat_hit = (h_cnt_d == H_MAX) && (h_cnt_q != H_MAX);
  end

  // Lock FSM: find a vsync, arm on the next line, then count good frames.
  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    armed_d      = armed_q;
    timing_err_d = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (vs_rise) begin
          state_d = ST_CHECK;
          good_d  = '0;
          armed_d = 1'b0;
        end
      end
      ST_CHECK, ST_LOCKED: begin
        if (h_sat_hit) begin
          timing_err_d = 1'b1;
        end else if (hs_rise) begin
          if (!armed_q) begin
            armed_d = 1'b1;
          end else if (!line_ok) begin
            timing_err_d = 1'b1;
          end else if (vs_pend_eff) begin
            if (!frame_ok) begin
              timing_err_d = 1'b1;
            end else if (state_q == ST_CHECK) begin
              good_d = good_q + GW'(1);
              if (good_d == GOOD_LOCK) state_d = ST_LOCKED;
            end
          end
        end
        if (timing_err_d) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Output stage: stream only active pixels while the next state is LOCKED.
  always_comb begin
    in_window = (h_cnt_d >= H_START) && (h_cnt_d <= H_END) &&
                (v_cnt_d >= V_START) && (v_cnt_d <= V_END);
    pix_valid_d   = (state_d == ST_LOCKED) && in_window;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_rgb_d     = pix_rgb_q;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;
    if (pix_valid_d) begin
      pix_x_d       = 10'(h_cnt_d - H_START);
      pix_y_d       = v_cnt_d - V_START;
      pix_rgb_d     = rgb_s1_q;
      line_start_d  = (h_cnt_d == H_START);
      frame_start_d = (h_cnt_d == H_START) && (v_cnt_d == V_START);
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SEARCH;
      rgb_s1_q      <= '0;
      hs_s1_q       <= 1'b0;
      hs_s2_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      h_cnt_q       <= '0;
      hs_w_q        <= '0;
      v_cnt_q       <= '0;
      vs_w_q        <= '0;
      vs_pend_q     <= 1'b0;
      armed_q       <= 1'b0;
      good_q        <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rgb_s1_q      <= rgb_s1_d;
      hs_s1_q       <= hs_s1_d;
      hs_s2_q       <= hs_s2_d;
      vs_s1_q       <= vs_s1_d;
      vs_s2_q       <= vs_s2_d;
      h_cnt_q       <= h_cnt_d;
      hs_w_q        <= hs_w_d;
      v_cnt_q       <= v_cnt_d;
      vs_w_q        <= vs_w_d;
      vs_pend_q     <= vs_pend_d;
      armed_q       <= armed_d;
      good_q        <= good_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_rgb_q     <= pix_rgb_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      timing_err_q  <= timing_err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign locked      = (state_q == ST_LOCKED);
  assign timing_err  = timing_err_q;

endmodule
